// File: rtl/al422_bam_row_scheduler.sv
// Bit-major BAM row scheduler: issues AL422 row loads to the first stage
// and overlaps each load with the display time of the previous row.
module al422_bam_row_scheduler #(
    parameter int ROW_COUNT    = 16,
    parameter int BIT_COUNT    = 8,
    parameter int OE_UNIT      = 2,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                         in_clk,
    input  logic                         in_nrst,
    input  logic                         enable,
    input  logic                         stage_busy,
    input  logic                         stage_ready,
    output logic                         module_start,
    output logic [2:0]                   bit_counter,
    output logic                         from_zero_address,
    output logic                         led_lat,
    output logic                         led_oe_n,
    output logic [$clog2(ROW_COUNT)-1:0] row_addr,
    output logic                         frame_done
);

    localparam int RW = $clog2(ROW_COUNT);
    localparam int OW = $clog2(OE_UNIT << (BIT_COUNT - 1)) + 1;
    localparam int BW = $clog2(BLANK_CYCLES) + 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACCEPT,
        WAIT_READY,
        WAIT_DISPLAY,
        BLANK,
        LATCH
    } state_t;

    state_t state_q, state_d;

    logic [2:0]    plane_q, plane_d;
    logic [RW-1:0] row_q, row_d;
    logic [OW-1:0] oe_cnt_q;
    logic [OW-1:0] oe_load;
    logic [BW-1:0] blk_cnt_q;
    logic          oe_idle;
    logic          last_load;
    logic          enter_issue;

    assign oe_idle     = (oe_cnt_q == '0);
    assign led_oe_n    = oe_idle;
    assign oe_load     = OW'(OE_UNIT) << plane_q;
    assign last_load   = (plane_q == 3'(BIT_COUNT - 1)) &&
                         (row_q == RW'(ROW_COUNT - 1));
    assign enter_issue = (state_d == ISSUE) && (state_q != ISSUE);

    always_ff @(posedge in_clk or negedge in_nrst) begin
        if (!in_nrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        plane_d = plane_q;
        row_d   = row_q;
        led_lat = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = ISSUE;
                    plane_d = '0;
                    row_d   = '0;
                end
            end
            ISSUE: state_d = WAIT_ACCEPT;
            WAIT_ACCEPT: begin
                if (stage_busy) state_d = WAIT_READY;
            end
            WAIT_READY: begin
                if (stage_ready && !stage_busy) state_d = WAIT_DISPLAY;
            end
            // a finished load waits here while the previous row is still lit
            WAIT_DISPLAY: begin
                if (oe_idle) state_d = BLANK;
            end
            BLANK: begin
                if (blk_cnt_q == '0) state_d = LATCH;
            end
            LATCH: begin
                led_lat = 1'b1;
                state_d = enable ? ISSUE : IDLE;
                if (row_q == RW'(ROW_COUNT - 1)) begin
                    row_d   = '0;
                    plane_d = (plane_q == 3'(BIT_COUNT - 1)) ?
                              3'd0 : plane_q + 3'd1;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_nrst) begin
        if (!in_nrst) begin
            plane_q           <= '0;
            row_q             <= '0;
            oe_cnt_q          <= '0;
            blk_cnt_q         <= '0;
            module_start      <= 1'b0;
            bit_counter       <= '0;
            from_zero_address <= 1'b0;
            row_addr          <= '0;
            frame_done        <= 1'b0;
        end else begin
            plane_q      <= plane_d;
            row_q        <= row_d;
            module_start <= (state_q == ISSUE);
            frame_done   <= (state_q == LATCH) && last_load;
            // load selectors settle during ISSUE, ahead of the start pulse
            if (enter_issue) begin
                bit_counter       <= plane_d;
                from_zero_address <= (row_d == '0);
            end
            if (state_q == LATCH) begin
                oe_cnt_q <= oe_load;
            end else if (!oe_idle) begin
                oe_cnt_q <= oe_cnt_q - OW'(1);
            end
            if ((state_q == WAIT_DISPLAY) && oe_idle) begin
                blk_cnt_q <= BW'(BLANK_CYCLES - 1);
                row_addr  <= row_q;
            end else if ((state_q == BLANK) && (blk_cnt_q != '0)) begin
                blk_cnt_q <= blk_cnt_q - BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_al422_bam_row_scheduler.sv
// Bench for al422_bam_row_scheduler: random-latency stage model plus
// an index-based reference of the bit-major scan, OE widths and timing.
module tb_al422_bam_row_scheduler;

    localparam int R   = 16;
    localparam int B   = 8;
    localparam int OEU = 2;
    localparam int BLK = 2;

    logic       in_clk = 1'b0;
    logic       in_nrst = 1'b0;
    logic       enable = 1'b0;
    logic       stage_busy = 1'b0;
    logic       stage_ready = 1'b0;
    logic       module_start;
    logic [2:0] bit_counter;
    logic       from_zero_address;
    logic       led_lat;
    logic       led_oe_n;
    logic [3:0] row_addr;
    logic       frame_done;

    int n_assert = 0;
    int n_fail = 0;
    int cyc = 0;

    int iss_bc[$];
    int iss_fz[$];
    int iss_ok[$];
    int rdy_cyc[$];
    int lat_row[$];
    int lat_cyc[$];
    int lat_off[$];
    int oe_run[$];
    int fd_cyc[$];

    int   run_len = 0;
    int   last_off = 0;
    logic prev_oe = 1'b1;
    logic prev_fz = 1'b0;
    logic [2:0] prev_bc = 3'd0;
    int   st_cnt = 0;
    int   len_min = 40;
    int   len_max = 40;

    al422_bam_row_scheduler #(
        .ROW_COUNT(R), .BIT_COUNT(B), .OE_UNIT(OEU), .BLANK_CYCLES(BLK)
    ) dut (
        .in_clk(in_clk),
        .in_nrst(in_nrst),
        .enable(enable),
        .stage_busy(stage_busy),
        .stage_ready(stage_ready),
        .module_start(module_start),
        .bit_counter(bit_counter),
        .from_zero_address(from_zero_address),
        .led_lat(led_lat),
        .led_oe_n(led_oe_n),
        .row_addr(row_addr),
        .frame_done(frame_done)
    );

    always #5 in_clk = ~in_clk;

    // observation recorder followed by the first-stage model
    always @(negedge in_clk) begin
        cyc++;
        if (!in_nrst) begin
            iss_bc.delete(); iss_fz.delete(); iss_ok.delete();
            rdy_cyc.delete(); lat_row.delete(); lat_cyc.delete();
            lat_off.delete(); oe_run.delete(); fd_cyc.delete();
            run_len = 0; last_off = 0; prev_oe = 1'b1; st_cnt = 0;
            stage_busy = 1'b0; stage_ready = 1'b0;
        end else begin
            if (module_start) begin
                iss_bc.push_back(int'(bit_counter));
                iss_fz.push_back(int'(from_zero_address));
                iss_ok.push_back(int'(prev_bc == bit_counter &&
                                      prev_fz == from_zero_address));
            end
            if (led_lat) begin
                lat_row.push_back(int'(row_addr));
                lat_cyc.push_back(cyc);
                lat_off.push_back(last_off);
            end
            if (frame_done) fd_cyc.push_back(cyc);
            if (!led_oe_n) begin
                run_len++;
            end else if (!prev_oe) begin
                oe_run.push_back(run_len);
                run_len = 0;
                last_off = cyc;
            end
            if (module_start) begin
                stage_ready = 1'b0;
                stage_busy = 1'b1;
                st_cnt = $urandom_range(len_max, len_min);
            end else if (stage_busy) begin
                st_cnt--;
                if (st_cnt == 0) begin
                    stage_busy = 1'b0;
                    stage_ready = 1'b1;
                    rdy_cyc.push_back(cyc + 1);
                end
            end
        end
        prev_oe = led_oe_n;
        prev_bc = bit_counter;
        prev_fz = from_zero_address;
    end

    task automatic wait_quiet(input string name);
        int t = 0;
        while (!(oe_run.size() == lat_cyc.size() &&
                 iss_bc.size() == lat_cyc.size() && led_oe_n) && t < 3000) begin
            @(negedge in_clk); t++;
        end
        repeat (2) @(negedge in_clk);
        n_assert++;
        if (t >= 3000) begin
            n_fail++;
            $display("FAIL %s_quiet: not idle after %0d cycles", name, t);
        end
    endtask

    task automatic test_reset();
        @(negedge in_clk); #1;
        in_nrst = 1'b0; enable = 1'b0;
        #1;
        n_assert++; if (module_start !== 1'b0) begin n_fail++; $display("FAIL rst_start got %b want 0", module_start); end
        n_assert++; if (bit_counter !== 3'd0) begin n_fail++; $display("FAIL rst_bc got %0d want 0", bit_counter); end
        n_assert++; if (from_zero_address !== 1'b0) begin n_fail++; $display("FAIL rst_fza got %b want 0", from_zero_address); end
        n_assert++; if (led_lat !== 1'b0) begin n_fail++; $display("FAIL rst_lat got %b want 0", led_lat); end
        n_assert++; if (led_oe_n !== 1'b1) begin n_fail++; $display("FAIL rst_oe_n got %b want 1", led_oe_n); end
        n_assert++; if (row_addr !== 4'd0) begin n_fail++; $display("FAIL rst_row got %0d want 0", row_addr); end
        n_assert++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_fd got %b want 0", frame_done); end
        repeat (3) @(negedge in_clk);
        #1 in_nrst = 1'b1;
        repeat (10) @(negedge in_clk);
        n_assert++; if (iss_bc.size() != 0) begin n_fail++; $display("FAIL idle_no_start got %0d starts want 0", iss_bc.size()); end
        n_assert++; if (led_oe_n !== 1'b1) begin n_fail++; $display("FAIL idle_oe_n got %b want 1", led_oe_n); end
    endtask

    task automatic test_first_load();
        int t = 0;
        len_min = 40; len_max = 40;
        @(negedge in_clk); #1 enable = 1'b1;
        while (iss_bc.size() == 0 && t < 20) begin @(negedge in_clk); t++; end
        #1 enable = 1'b0;
        t = 0;
        while (lat_cyc.size() == 0 && t < 300) begin @(negedge in_clk); t++; end
        repeat (20) @(negedge in_clk);
        n_assert++;
        if (lat_cyc.size() != 1 || iss_bc.size() != 1 || rdy_cyc.size() != 1 || oe_run.size() != 1) begin
            n_fail++;
            $display("FAIL first_counts got iss=%0d lat=%0d rdy=%0d runs=%0d want 1 each",
                     iss_bc.size(), lat_cyc.size(), rdy_cyc.size(), oe_run.size());
        end else begin
            n_assert++; if (iss_bc[0] != 0) begin n_fail++; $display("FAIL first_bc got %0d want 0", iss_bc[0]); end
            n_assert++; if (iss_fz[0] != 1) begin n_fail++; $display("FAIL first_fza got %0d want 1", iss_fz[0]); end
            n_assert++; if (iss_ok[0] != 1) begin n_fail++; $display("FAIL first_setup got %0d want 1", iss_ok[0]); end
            n_assert++; if (lat_cyc[0] != rdy_cyc[0] + 1 + BLK) begin n_fail++; $display("FAIL first_lat_time got %0d want %0d", lat_cyc[0], rdy_cyc[0] + 1 + BLK); end
            n_assert++; if (lat_row[0] != 0) begin n_fail++; $display("FAIL first_row got %0d want 0", lat_row[0]); end
            n_assert++; if (oe_run[0] != OEU) begin n_fail++; $display("FAIL first_oe got %0d want %0d", oe_run[0], OEU); end
        end
        n_assert++; if (fd_cyc.size() != 0) begin n_fail++; $display("FAIL first_fd got %0d want 0", fd_cyc.size()); end
        n_assert++; if (led_oe_n !== 1'b1) begin n_fail++; $display("FAIL first_idle_oe got %b want 1", led_oe_n); end
    endtask

    task automatic test_full_frame();
        int t = 0;
        int n, nh, nfz, plane, row, e;
        @(negedge in_clk); #1 in_nrst = 1'b0;
        repeat (2) @(negedge in_clk);
        len_min = 3; len_max = 60;
        #1 in_nrst = 1'b1; enable = 1'b1;
        while (lat_cyc.size() < R * B + 1 && t < 60000) begin @(negedge in_clk); t++; end
        #1 enable = 1'b0;
        wait_quiet("frame");
        n = lat_cyc.size();
        n_assert++; if (n < R * B + 1) begin n_fail++; $display("FAIL frame_latches got %0d want >= %0d", n, R * B + 1); end
        n_assert++;
        if (iss_bc.size() != n || oe_run.size() != n || rdy_cyc.size() != n) begin
            n_fail++;
            $display("FAIL frame_counts got iss=%0d runs=%0d rdy=%0d want %0d",
                     iss_bc.size(), oe_run.size(), rdy_cyc.size(), n);
            n = 0;
        end
        nh = 0; nfz = 0;
        for (int k = 0; k < n; k++) begin
            plane = (k / R) % B;
            row = k % R;
            e = (lat_off[k] > rdy_cyc[k]) ? lat_off[k] : rdy_cyc[k];
            if (lat_off[k] > rdy_cyc[k]) nh++;
            if (k < R * B) nfz += iss_fz[k];
            n_assert++; if (iss_bc[k] != plane) begin n_fail++; $display("FAIL frame_bc[%0d] got %0d want %0d", k, iss_bc[k], plane); end
            n_assert++; if (iss_fz[k] != int'(row == 0)) begin n_fail++; $display("FAIL frame_fza[%0d] got %0d want %0d", k, iss_fz[k], row == 0); end
            n_assert++; if (iss_ok[k] != 1) begin n_fail++; $display("FAIL frame_setup[%0d] got %0d want 1", k, iss_ok[k]); end
            n_assert++; if (lat_row[k] != row) begin n_fail++; $display("FAIL frame_row[%0d] got %0d want %0d", k, lat_row[k], row); end
            n_assert++; if (oe_run[k] != (OEU << plane)) begin n_fail++; $display("FAIL frame_oe[%0d] got %0d want %0d", k, oe_run[k], OEU << plane); end
            n_assert++; if (lat_cyc[k] != e + 1 + BLK) begin n_fail++; $display("FAIL frame_lat_time[%0d] got %0d want %0d", k, lat_cyc[k], e + 1 + BLK); end
        end
        n_assert++; if (nfz != B) begin n_fail++; $display("FAIL frame_fza_count got %0d want %0d", nfz, B); end
        n_assert++; if (nh == 0) begin n_fail++; $display("FAIL frame_holdoff got 0 held-off loads want >0"); end
        n_assert++;
        if (fd_cyc.size() != 1) begin
            n_fail++; $display("FAIL frame_done_count got %0d want 1", fd_cyc.size());
        end else if (lat_cyc.size() >= R * B) begin
            n_assert++;
            if (fd_cyc[0] != lat_cyc[R * B - 1] + 1) begin
                n_fail++; $display("FAIL frame_done_time got %0d want %0d", fd_cyc[0], lat_cyc[R * B - 1] + 1);
            end
        end
    endtask

    task automatic test_disable_restart();
        int t = 0;
        int n0;
        @(negedge in_clk); #1 in_nrst = 1'b0;
        repeat (2) @(negedge in_clk);
        len_min = 5; len_max = 30;
        #1 in_nrst = 1'b1; enable = 1'b1;
        while (lat_cyc.size() < 20 && t < 20000) begin @(negedge in_clk); t++; end
        #1 enable = 1'b0;
        wait_quiet("disable");
        n0 = lat_cyc.size();
        n_assert++; if (iss_bc.size() != n0) begin n_fail++; $display("FAIL dis_no_lost got iss=%0d want %0d", iss_bc.size(), n0); end
        n_assert++; if (oe_run.size() != n0 || n0 == 0) begin n_fail++; $display("FAIL dis_displayed got runs=%0d want %0d", oe_run.size(), n0); end
        else begin
            n_assert++;
            if (oe_run[n0 - 1] != (OEU << (((n0 - 1) / R) % B))) begin
                n_fail++; $display("FAIL dis_last_oe got %0d want %0d", oe_run[n0 - 1], OEU << (((n0 - 1) / R) % B));
            end
            n_assert++; if (lat_row[n0 - 1] != (n0 - 1) % R) begin n_fail++; $display("FAIL dis_last_row got %0d want %0d", lat_row[n0 - 1], (n0 - 1) % R); end
        end
        repeat (50) @(negedge in_clk);
        n_assert++; if (iss_bc.size() != n0 || lat_cyc.size() != n0) begin n_fail++; $display("FAIL dis_idle got iss=%0d lat=%0d want %0d", iss_bc.size(), lat_cyc.size(), n0); end
        n_assert++; if (led_oe_n !== 1'b1) begin n_fail++; $display("FAIL dis_oe_n got %b want 1", led_oe_n); end
        #1 enable = 1'b1;
        t = 0;
        while (lat_cyc.size() <= n0 && t < 500) begin @(negedge in_clk); t++; end
        n_assert++;
        if (lat_cyc.size() <= n0 || iss_bc.size() <= n0) begin
            n_fail++; $display("FAIL re_en_timeout got lat=%0d want > %0d", lat_cyc.size(), n0);
        end else begin
            n_assert++; if (iss_bc[n0] != 0) begin n_fail++; $display("FAIL re_en_bc got %0d want 0", iss_bc[n0]); end
            n_assert++; if (iss_fz[n0] != 1) begin n_fail++; $display("FAIL re_en_fza got %0d want 1", iss_fz[n0]); end
            n_assert++; if (lat_row[n0] != 0) begin n_fail++; $display("FAIL re_en_row got %0d want 0", lat_row[n0]); end
        end
    endtask

    task automatic test_reset_mid_display();
        int t = 0;
        int target;
        target = lat_cyc.size() + R + 3;
        while (lat_cyc.size() < target && t < 20000) begin @(negedge in_clk); t++; end
        t = 0;
        while (led_oe_n !== 1'b0 && t < 2000) begin @(negedge in_clk); t++; end
        n_assert++; if (led_oe_n !== 1'b0) begin n_fail++; $display("FAIL mid_oe_on got %b want 0", led_oe_n); end
        #2 in_nrst = 1'b0;
        #1;
        n_assert++; if (led_oe_n !== 1'b1) begin n_fail++; $display("FAIL mid_oe_n got %b want 1", led_oe_n); end
        n_assert++; if (module_start !== 1'b0) begin n_fail++; $display("FAIL mid_start got %b want 0", module_start); end
        n_assert++; if (bit_counter !== 3'd0) begin n_fail++; $display("FAIL mid_bc got %0d want 0", bit_counter); end
        n_assert++; if (from_zero_address !== 1'b0) begin n_fail++; $display("FAIL mid_fza got %b want 0", from_zero_address); end
        n_assert++; if (led_lat !== 1'b0) begin n_fail++; $display("FAIL mid_lat got %b want 0", led_lat); end
        n_assert++; if (row_addr !== 4'd0) begin n_fail++; $display("FAIL mid_row got %0d want 0", row_addr); end
        n_assert++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL mid_fd got %b want 0", frame_done); end
        enable = 1'b0;
        repeat (3) @(negedge in_clk);
        #1 in_nrst = 1'b1;
        repeat (5) @(negedge in_clk);
        n_assert++; if (led_oe_n !== 1'b1 || iss_bc.size() != 0) begin n_fail++; $display("FAIL post_rst_idle got oe_n=%b starts=%0d want 1/0", led_oe_n, iss_bc.size()); end
    endtask

    initial begin
        test_reset();
        test_first_load();
        test_full_frame();
        test_disable_restart();
        test_reset_mid_display();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
